// File: rtl/seq_add_pkg.sv
// rtl/seq_add_pkg.sv - shared FSM encoding and counter sizing for the multi-word add sequencer

package seq_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Word counter width: clog2 of the word count, never narrower than one bit.
    function automatic int cnt_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/multi_bit_full_adder.sv
// rtl/multi_bit_full_adder.sv - N-bit ripple adder with carry in and carry out

module multi_bit_full_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    output logic [N-1:0] sum,
    output logic         carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, carry_in};

endmodule

// File: rtl/multi_word_add_sequencer.sv
// rtl/multi_word_add_sequencer.sv - word-serial wide adder over one shared N-bit adder
// Optional signed overflow flag enabled by macro SEQ_ADD_OVERFLOW_EN.

module multi_word_add_sequencer
    import seq_add_pkg::*;
#(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               input_clock,
    input  logic               input_reset,
    input  logic               input_start_valid,
    output logic               output_start_ready,
    input  logic [N*WORDS-1:0] input_a,
    input  logic [N*WORDS-1:0] input_b,
    input  logic               input_carry,
    output logic [N*WORDS-1:0] output_sum,
    output logic               output_carry,
    output logic               output_overflow,
    output logic               output_done_valid,
    input  logic               input_done_ready
);

    localparam int CW = cnt_width(WORDS);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            run_carry;
    logic            carry_q;
    logic            last_word;
    logic [N-1:0]    a_words   [WORDS];
    logic [N-1:0]    b_words   [WORDS];
    logic [N-1:0]    sum_words [WORDS];
    logic [N-1:0]    add_a;
    logic [N-1:0]    add_b;
    logic [N-1:0]    add_sum;
    logic            add_cout;

    assign last_word = (cnt == CW'(WORDS - 1));
    assign add_a     = a_words[cnt];
    assign add_b     = b_words[cnt];

    multi_bit_full_adder #(.N(N)) u_adder (
        .a         (add_a),
        .b         (add_b),
        .carry_in  (run_carry),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    always_ff @(posedge input_clock) begin
        if (input_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            run_carry <= 1'b0;
            carry_q   <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                sum_words[i] <= '0;
                a_words[i]   <= '0;
                b_words[i]   <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (input_start_valid) begin
                        for (int i = 0; i < WORDS; i++) begin
                            a_words[i] <= input_a[i*N +: N];
                            b_words[i] <= input_b[i*N +: N];
                        end
                        cnt       <= '0;
                        run_carry <= input_carry;
                    end
                end
                RUN: begin
                    sum_words[cnt] <= add_sum;
                    run_carry      <= add_cout;
                    cnt            <= cnt + CW'(1);
                    if (last_word) begin
                        carry_q <= add_cout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_ADD_OVERFLOW_EN
    logic ovf_q;

    // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
    always_ff @(posedge input_clock) begin
        if (input_reset) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && last_word) begin
            ovf_q <= add_a[N-1] ^ add_b[N-1] ^ add_sum[N-1] ^ add_cout;
        end
    end

    assign output_overflow = ovf_q;
`else
    assign output_overflow = 1'b0;
`endif

    always_comb begin
        state_next         = state;
        output_start_ready = 1'b0;
        output_done_valid  = 1'b0;
        case (state)
            IDLE: begin
                output_start_ready = 1'b1;
                if (input_start_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_word) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                output_done_valid = 1'b1;
                if (input_done_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_sum
        assign output_sum[g*N +: N] = sum_words[g];
    end

    assign output_carry = carry_q;

endmodule

// File: tb/tb_multi_word_add_sequencer.sv
// tb/tb_multi_word_add_sequencer.sv - self-checking bench for multi_word_add_sequencer (N=8, WORDS=4)

module tb_multi_word_add_sequencer;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

`ifdef SEQ_ADD_OVERFLOW_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         done_valid;
    logic         done_ready = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit cmp_en    = 1'b0;

    always #5 clk = ~clk;

    multi_word_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
        .input_clock        (clk),
        .input_reset        (rst),
        .input_start_valid  (start_valid),
        .output_start_ready (start_ready),
        .input_a            (a),
        .input_b            (b),
        .input_carry        (cin),
        .output_sum         (sum),
        .output_carry       (cout),
        .output_overflow    (ovf),
        .output_done_valid  (done_valid),
        .input_done_ready   (done_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Transaction-level model: result is plain wide arithmetic, timing is "busy for WORDS edges".
    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    function automatic res_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        res_t r;
        logic [W:0] full;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        r.s  = full[W-1:0];
        r.c  = full[W];
        r.v  = OVF_ON && (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
        return r;
    endfunction

    int   m_phase = 0;  // 0 waiting, 1 computing, 2 holding result
    int   m_left  = 0;
    res_t m_pend  = '0;
    res_t m_res   = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_res   <= '0;
        end else begin
            case (m_phase)
                0: if (start_valid) begin
                    m_phase <= 1;
                    m_left  <= WORDS;
                    m_pend  <= ref_add(a, b, cin);
                end
                1: if (m_left == 1) begin
                    m_phase <= 2;
                    m_res   <= m_pend;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (done_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_start_ready", 64'(start_ready), 64'(m_phase == 0));
            check("model_done_valid", 64'(done_valid), 64'(m_phase == 2));
            if (m_phase != 1) begin
                check("model_sum", 64'(sum), 64'(m_res.s));
                check("model_carry", 64'(cout), 64'(m_res.c));
                check("model_overflow", 64'(ovf), 64'(m_res.v));
            end
        end
    end

    task automatic accept(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
        @(negedge clk);
        a = xa; b = xb; cin = xc; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!done_valid && edges < 20) begin
            @(posedge clk);
            #1 edges++;
        end
    endtask

    task automatic release_done();
        @(negedge clk);
        done_ready = 1'b1;
        @(posedge clk);
        #1 done_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic xc, input logic [W-1:0] es, input logic ec, input logic ev);
        int edges;
        accept(xa, xb, xc);
        wait_done(edges);
        check({name, "_latency"}, 64'(edges), 64'(WORDS));
        check({name, "_sum"}, 64'(sum), 64'(es));
        check({name, "_carry"}, 64'(cout), 64'(ec));
        check({name, "_overflow"}, 64'(ovf), 64'(ev));
        release_done();
    endtask

    initial begin
        int edges;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        check("reset_start_ready", 64'(start_ready), 64'd1);
        check("reset_done_valid", 64'(done_valid), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);

        run_op("ff_plus_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        check("idle_retains_carry", 64'(cout), 64'd1);
        run_op("max_pos_plus_1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, OVF_ON);
        run_op("cin_only", 32'h0, 32'h0, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
        run_op("min_neg_twice", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, OVF_ON);

        // Stray requests during RUN and DONE, and a stalled consumer.
        accept(32'h1234_5678, 32'h1111_1111, 1'b0);
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        wait_done(edges);
        check("stall_latency", 64'(edges), 64'(WORDS - 1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_valid = (i % 2 == 0);
            check("stall_done_valid", 64'(done_valid), 64'd1);
            check("stall_sum", 64'(sum), 64'h2345_6789);
            check("stall_carry", 64'(cout), 64'd0);
        end
        @(negedge clk);
        start_valid = 1'b0;
        release_done();
        check("stall_back_to_idle", 64'(start_ready), 64'd1);

        // Reset on the second RUN edge discards the partial result.
        accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrun_reset_ready", 64'(start_ready), 64'd1);
        check("midrun_reset_done", 64'(done_valid), 64'd0);
        check("midrun_reset_sum", 64'(sum), 64'd0);
        check("midrun_reset_carry", 64'(cout), 64'd0);
        run_op("after_reset", 32'h00FF_00FF, 32'h0F0F_0F0F, 1'b0, 32'h100E_100E, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/multi_word_add_sequencer.md
MULTI_WORD_ADD_SEQUENCER -- requirements
Module: multi_word_add_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the adder word width in bits.
REQ-002 The block SHALL have parameter WORDS, default 4, giving the operand length in words (WORDS >= 1).
REQ-003 The block SHALL have port input_clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port input_reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port input_start_valid, input, 1 bit: a request with operands is present.
REQ-006 The block SHALL have port output_start_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port input_a, input, N*WORDS bits: operand A, two's complement, word 0 in the LSBs.
REQ-008 The block SHALL have port input_b, input, N*WORDS bits: operand B, same layout as A.
REQ-009 The block SHALL have port input_carry, input, 1 bit: carry into word 0.
REQ-010 The block SHALL have port output_sum, output, N*WORDS bits: the registered result.
REQ-011 The block SHALL have port output_carry, output, 1 bit: carry out of the top word.
REQ-012 The block SHALL have port output_overflow, output, 1 bit: signed overflow flag.
REQ-013 The block SHALL have port output_done_valid, output, 1 bit: the result is valid.
REQ-014 The block SHALL have port input_done_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 output_start_ready SHALL be 1 only in IDLE; output_done_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, if input_start_valid=1, the rising edge SHALL latch input_a, input_b and input_carry, clear the word counter and enter RUN; otherwise IDLE holds.
REQ-018 In RUN, each cycle SHALL add operand word[cnt] plus the running carry through the one shared N-bit adder, register the result into sum word[cnt], register the carry-out as the running carry, and increment cnt.
REQ-019 On the edge that processes word WORDS-1, the FSM SHALL enter DONE; output_done_valid SHALL therefore rise exactly WORDS edges after the accepting edge.
REQ-020 In DONE, outputs SHALL hold stable until the edge with input_done_ready=1, which SHALL return the FSM to IDLE.
REQ-021 input_start_valid SHALL be ignored in RUN and DONE; operand inputs SHALL be sampled only on the accepting edge.
REQ-022 output_carry SHALL equal the carry out of word WORDS-1, i.e. bit N*WORDS of the full-width unsigned sum A+B+carry_in.
REQ-023 With WORDS=1, RUN SHALL last exactly one cycle.
REQ-024 output_sum, output_carry and output_overflow SHALL retain the last result in IDLE until the next RUN overwrites them.

Reset
REQ-025 input_reset=1 on a rising edge SHALL force IDLE from any state, including mid-RUN, and clear cnt, the running carry, output_sum, output_carry and output_overflow to 0.
REQ-026 On the first edge after reset, output_start_ready SHALL be 1 and output_done_valid SHALL be 0; a partially computed result SHALL be discarded.

Configuration
REQ-027 Macro SEQ_ADD_OVERFLOW_EN defined: output_overflow SHALL equal carry-into XOR carry-out of the MSB of word WORDS-1, registered on the final RUN edge.
REQ-028 Macro SEQ_ADD_OVERFLOW_EN undefined: output_overflow SHALL be tied to constant 0 and SHALL have no overflow logic.

Structure
REQ-029 The state encoding (IDLE/RUN/DONE) and the counter-width constant (clog2 of WORDS, minimum 1) SHALL live in the shared package seq_add_pkg.
REQ-030 The block SHALL instantiate exactly one multi_bit_full_adder sub-module with #(.N(N)), fed by the word-select mux; it SHALL contain no other adder.

Verification (N=8, WORDS=4)
REQ-031 A=0xFFFFFFFF, B=0x00000001, cin=0 -> sum=0x00000000, carry=1, overflow=0, done_valid rises 4 edges after acceptance.
REQ-032 A=0x7FFFFFFF, B=0x00000001, cin=0 -> sum=0x80000000, carry=0, overflow=1 (0 when SEQ_ADD_OVERFLOW_EN is undefined).
REQ-033 A=0, B=0, cin=1 -> sum=0x00000001, carry=0; then A=0x80000000, B=0x80000000 -> sum=0, carry=1, overflow=1.
REQ-034 done_ready held 0 for 5 cycles -> sum/done_valid stable; start_valid pulsed with new operands during RUN and DONE -> ignored, result unchanged.
REQ-035 Reset asserted on the 2nd RUN cycle -> next edge IDLE, start_ready=1, done_valid=0, sum=0; a following request computes correctly.
